// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the ALU (A) and load (M) write-backs.
// Latency: accept at edge N, wr_en high after edge N+1 when uncontended; a loser waits at most one extra cycle.
// Backpressure: x_ready = !full_x | grant_x, driven only by registered state, so one write per cycle is sustained.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDR_W-1:0]        a_reg,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [ADDR_W-1:0]        m_reg,
  input  logic [DATA_W-1:0]        m_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_reg,
  output logic [DATA_W-1:0]        wr_data,
  output logic [(1<<ADDR_W)-1:0]   pending
);

  // Holding buffers
  logic              full_a, full_m;
  logic [ADDR_W-1:0] buf_a_reg, buf_m_reg;
  logic [DATA_W-1:0] buf_a_data, buf_m_data;

  // Age flags: older_a / older_m say which entry was loaded on an earlier edge.
  // Both clear while both are full means they were loaded on the same edge.
  logic older_a, older_m;

  // Round-robin tie-break for same-edge loads to different registers (0 = A, 1 = M).
  logic rr_ptr;

  logic              grant_a, grant_m, rr_used;
  logic              load_a, load_m, keep_a, keep_m;
  logic              any_grant, discard;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  // Grant selection from buffer state only (no valid-to-ready path).
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    rr_used = 1'b0;
    if (full_a && !full_m) begin
      grant_a = 1'b1;
    end else if (!full_a && full_m) begin
      grant_m = 1'b1;
    end else if (full_a && full_m) begin
      if (older_a) begin
        grant_a = 1'b1;
      end else if (older_m) begin
        grant_m = 1'b1;
      end else if (buf_a_reg == buf_m_reg) begin
        // Same destination: M first so the ALU value lands last.
        grant_m = 1'b1;
      end else begin
        rr_used = 1'b1;
        if (rr_ptr) grant_m = 1'b1;
        else        grant_a = 1'b1;
      end
    end
  end

  assign a_ready   = !full_a || grant_a;
  assign m_ready   = !full_m || grant_m;
  assign load_a    = a_valid && a_ready;
  assign load_m    = m_valid && m_ready;
  assign keep_a    = full_a && !grant_a;
  assign keep_m    = full_m && !grant_m;
  assign any_grant = grant_a || grant_m;
  assign sel_reg   = grant_m ? buf_m_reg  : buf_a_reg;
  assign sel_data  = grant_m ? buf_m_data : buf_a_data;
  assign discard   = ZERO_DISCARD && (sel_reg == '0);

  // Buffer, age, round-robin and output-stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_a     <= 1'b0;
      full_m     <= 1'b0;
      buf_a_reg  <= '0;
      buf_a_data <= '0;
      buf_m_reg  <= '0;
      buf_m_data <= '0;
      older_a    <= 1'b0;
      older_m    <= 1'b0;
      rr_ptr     <= 1'b0;
      wr_en      <= 1'b0;
      wr_reg     <= '0;
      wr_data    <= '0;
    end else begin
      if (load_a) begin
        full_a     <= 1'b1;
        buf_a_reg  <= a_reg;
        buf_a_data <= a_data;
      end else if (grant_a) begin
        full_a <= 1'b0;
      end

      if (load_m) begin
        full_m     <= 1'b1;
        buf_m_reg  <= m_reg;
        buf_m_data <= m_data;
      end else if (grant_m) begin
        full_m <= 1'b0;
      end

      // The entry that survives an edge without being granted is older than a fresh load.
      if (load_a && load_m) begin
        older_a <= 1'b0;
        older_m <= 1'b0;
      end else if (load_a && keep_m) begin
        older_a <= 1'b0;
        older_m <= 1'b1;
      end else if (keep_a && load_m) begin
        older_a <= 1'b1;
        older_m <= 1'b0;
      end else begin
        older_a <= 1'b0;
        older_m <= 1'b0;
      end

      if (rr_used) rr_ptr <= ~rr_ptr;

      wr_en <= any_grant && !discard;
      if (any_grant && !discard) begin
        wr_reg  <= sel_reg;
        wr_data <= sel_data;
      end
    end
  end

  // Pending mask: buffered destinations plus the write currently on the port.
  always_comb begin
    pending = '0;
    if (full_a) pending[buf_a_reg] = 1'b1;
    if (full_m) pending[buf_m_reg] = 1'b1;
    if (wr_en)  pending[wr_reg]    = 1'b1;
    if (ZERO_DISCARD) pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected writes, a monitor checks wr_* at negedge.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, m_valid;
  logic        a_ready, m_ready;
  logic [4:0]  a_reg, m_reg;
  logic [31:0] a_data, m_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [31:0] pending;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .ZERO_DISCARD(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_reg(m_reg), .m_data(m_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d, input int c);
    exp_t e;
    e.r = r;
    e.d = d;
    e.c = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every wr_en pulse must match the head of the scoreboard, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: reg %0d data 0x%0h at cycle %0d, expected none", wr_reg, wr_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("wr_reg", {27'd0, wr_reg}, {27'd0, e.r});
          check("wr_data", wr_data, e.d);
          check("wr_cycle", cyc, e.c);
        end
      end
    end
  end

  initial begin
    int  e0;
    int  ai, mi;
    logic ra, rm;

    rst = 1'b1;
    a_valid = 1'b0; m_valid = 1'b0;
    a_reg = '0; m_reg = '0; a_data = '0; m_data = '0;
    tick();
    tick();
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_a_ready", {31'd0, a_ready}, 32'd1);
    check("rst_m_ready", {31'd0, m_ready}, 32'd1);
    check("rst_wr_data", wr_data, 32'd0);
    rst = 1'b0;
    tick();

    // Single ALU write, uncontended.
    e0 = cyc;
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hDEADBEEF;
    push(5'd3, 32'hDEADBEEF, e0 + 2);
    tick();
    a_valid = 1'b0;
    check("t2_pending_buf", {31'd0, pending[3]}, 32'd1);
    tick();
    check("t2_pending_wr", {31'd0, pending[3]}, 32'd1);
    tick();
    check("t2_pending_clear", pending, 32'd0);

    // Same-edge loads, different regs, rr_ptr at A.
    e0 = cyc;
    a_valid = 1'b1; a_reg = 5'd4; a_data = 32'h11;
    m_valid = 1'b1; m_reg = 5'd5; m_data = 32'h22;
    push(5'd4, 32'h11, e0 + 2);
    push(5'd5, 32'h22, e0 + 3);
    tick();
    a_valid = 1'b0; m_valid = 1'b0;
    check("t3_pending_both", pending, 32'h0000_0030);
    tick(); tick(); tick();

    // Same-edge loads to the same reg: M lands first, A last.
    e0 = cyc;
    a_valid = 1'b1; a_reg = 5'd7; a_data = 32'hAA;
    m_valid = 1'b1; m_reg = 5'd7; m_data = 32'hBB;
    push(5'd7, 32'hBB, e0 + 2);
    push(5'd7, 32'hAA, e0 + 3);
    tick();
    a_valid = 1'b0; m_valid = 1'b0;
    tick(); tick(); tick();

    // Reset while a write is buffered: it must never reach wr_en.
    a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h99;
    tick();
    a_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_pending", pending, 32'd0);
    check("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    check("midrst_a_ready", {31'd0, a_ready}, 32'd1);
    tick(); tick();

    // Both requesters streaming for 20 edges: writes alternate A/M every cycle.
    e0 = cyc;
    for (int i = 0; i < 21; i++) begin
      int k;
      k = i / 2;
      if (i % 2 == 0) push(5'(8 + (k % 4)), 32'hA000_0000 + 32'(k), e0 + 2 + i);
      else            push(5'(16 + (k % 4)), 32'hB000_0000 + 32'(k), e0 + 2 + i);
    end
    ai = 0; mi = 0;
    a_valid = 1'b1; m_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      a_reg  = 5'(8 + (ai % 4));
      a_data = 32'hA000_0000 + 32'(ai);
      m_reg  = 5'(16 + (mi % 4));
      m_data = 32'hB000_0000 + 32'(mi);
      @(negedge clk);
      ra = a_ready;
      rm = m_ready;
      tick();
      if (ra) ai++;
      if (rm) mi++;
    end
    a_valid = 1'b0; m_valid = 1'b0;
    check("t5_a_accepts", 32'(ai), 32'd11);
    check("t5_m_accepts", 32'(mi), 32'd10);
    for (int n = 0; n < 5; n++) tick();
    check("t5_drained", pending, 32'd0);

    // Write to register 0 is accepted and silently dropped.
    a_valid = 1'b1; a_reg = 5'd0; a_data = 32'h5;
    check("t6_a_ready", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      check("t6_pending0", {31'd0, pending[0]}, 32'd0);
      check("t6_wr_en", {31'd0, wr_en}, 32'd0);
      tick();
    end
    check("t6_a_ready_after", {31'd0, a_ready}, 32'd1);

    tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
